// File: rtl/pipeline_register.sv
// Elastic valid/ready pipeline of DEPTH register stages, WIDTH bits per word.
// Empty stages always accept a word, so gaps between words close up while the
// consumer stalls. Reset clears valid bits and data. Flush clears only the
// valid bits. While reset or flush is high, both handshakes are blocked.
module pipeline_register #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_p;
    logic [WIDTH-1:0] data_p [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             blocked;
    logic [OCC_W-1:0] occ;

    assign blocked = reset || flush;

    // Stage i may advance when out_ready is high or any stage from i to the output is empty.
    // This is the unrolled form of rdy[i] = !valid[i] || rdy[i+1], with no self-referencing chain.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!valid_p[j]) begin
                    rdy[i] = 1'b1;
                end
            end
        end
    end

    // Stage registers: reset clears everything, flush drops the words, otherwise advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_p <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_p[i] <= '0;
            end
        end else if (flush) begin
            valid_p <= '0;
        end else begin
            if (rdy[0]) begin
                valid_p[0] <= in_valid;
                if (in_valid) begin
                    data_p[0] <= in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    valid_p[i] <= valid_p[i-1];
                    if (valid_p[i-1]) begin
                        data_p[i] <= data_p[i-1];
                    end
                end
            end
        end
    end

    // Occupancy is the number of set valid bits.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(valid_p[i]);
        end
    end

    assign in_ready  = rdy[0] && !blocked;
    assign out_valid = valid_p[DEPTH-1] && !blocked;
    assign out_data  = data_p[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_pipeline_register.sv
// Bench for pipeline_register at WIDTH=4 and DEPTH=3. It holds a queue model of
// in-flight words and their stage positions, and checks every cycle against it.
// Directed scenarios add literal expectations.
module tb_pipeline_register;

    localparam int W = 4;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    pipeline_register #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: the words in flight, oldest first, each with its stage position.
    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } ent_t;
    ent_t         q[$];
    logic [W-1:0] last_out = '0;
    bit           chk_en = 0;
    int           cyc = 0;

    function automatic bit m_in_ready();
        return !(reset || flush) && (q.size() < D || out_ready);
    endfunction

    function automatic bit m_out_valid();
        return !(reset || flush) && q.size() > 0 && q[0].pos == D-1;
    endfunction

    // Advance the model at each rising edge.
    initial begin
        ent_t nq[$];
        int   limit;
        int   np;
        bit   acc;
        bit   pop;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                q.delete();
                last_out = '0;
                chk_en = 1;
            end else if (flush) begin
                q.delete();
            end else begin
                acc = m_in_ready() && in_valid;
                pop = m_out_valid() && out_ready;
                nq.delete();
                limit = D-1;
                for (int k = 0; k < q.size(); k++) begin
                    if (!(k == 0 && pop)) begin
                        np = (q[k].pos + 1 < limit) ? q[k].pos + 1 : limit;
                        nq.push_back('{d: q[k].d, pos: np});
                        limit = np - 1;
                    end
                end
                if (acc) nq.push_back('{d: in_data, pos: 0});
                q = nq;
                if (q.size() > 0 && q[0].pos == D-1) last_out = q[0].d;
            end
        end
    end

    // Transfers seen on each side, with the cycle in which they happened.
    int outq[$];
    int out_cyc[$];
    int in_cyc[$];

    // Compare the DUT with the model on every falling edge and log handshakes.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready",  int'(in_ready),  int'(m_in_ready()));
                check("out_valid", int'(out_valid), int'(m_out_valid()));
                check("out_data",  int'(out_data),  int'(last_out));
                check("occupancy", int'(occupancy), q.size());
            end
            if (out_valid && out_ready) begin
                outq.push_back(int'(out_data));
                out_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) in_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data = v;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("push_accept", int'(done), 1);
    endtask

    task automatic clear_logs();
        outq.delete();
        out_cyc.delete();
        in_cyc.delete();
    endtask

    initial begin
        int n_in;
        int n_out;

        // 1: a word offered during reset is not captured.
        reset = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
        #4;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #3;
        check("post_rst_out_data", int'(out_data), 0);
        check("post_rst_occ", int'(occupancy), 0);
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_out_valid", int'(out_valid), 0);
        tick(); tick();
        check("post_rst_nothing_out", outq.size(), 0);

        // 2: 16 words back to back with out_ready held high.
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data = W'(i);
            if (i == 10) begin
                #3;
                check("stream_occ_steady", int'(occupancy), 3);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check("stream_count", outq.size(), 16);
        for (int k = 0; k < 16 && k < outq.size() && k < in_cyc.size(); k++) begin
            check("stream_data", outq[k], k);
            check("stream_latency", out_cyc[k] - in_cyc[k], 3);
            if (k > 0) check("stream_contiguous", out_cyc[k] - out_cyc[k-1], 1);
        end

        // 3: back-pressure fills the pipe, then release drains in order.
        clear_logs();
        out_ready = 1'b0;
        push(4'h1); push(4'h2); push(4'h3);
        in_valid = 1'b1; in_data = 4'h4;
        #3;
        check("full_in_ready", int'(in_ready), 0);
        check("full_occ", int'(occupancy), 3);
        check("full_out_data", int'(out_data), 1);
        tick();
        check("full_held_out_data", int'(out_data), 1);
        out_ready = 1'b1;
        push(4'h4); push(4'h5);
        repeat (5) tick();
        check("bp_count", outq.size(), 5);
        for (int k = 0; k < outq.size() && k < 5; k++) check("bp_order", outq[k], k + 1);

        // 4: a gap between two words closes up while stalled.
        clear_logs();
        out_ready = 1'b0;
        push(4'hA);
        tick(); tick();
        push(4'hB);
        tick();
        #3;
        check("bubble_occ", int'(occupancy), 2);
        check("bubble_out_valid", int'(out_valid), 1);
        check("bubble_out_data", int'(out_data), 4'hA);
        out_ready = 1'b1;
        repeat (4) tick();
        check("bubble_count", outq.size(), 2);
        if (outq.size() == 2) begin
            check("bubble_first", outq[0], 4'hA);
            check("bubble_second", outq[1], 4'hB);
            check("bubble_consecutive", out_cyc[1] - out_cyc[0], 1);
        end

        // 5: a flush discards the held words and the offered word.
        clear_logs();
        out_ready = 1'b0;
        push(4'hC); push(4'hD); push(4'hE);
        #3;
        check("pre_flush_occ", int'(occupancy), 3);
        tick();
        flush = 1'b1; in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
        n_in = in_cyc.size();
        n_out = outq.size();
        #3;
        check("flush_in_ready", int'(in_ready), 0);
        check("flush_out_valid", int'(out_valid), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #3;
        check("flush_no_in_xfer", in_cyc.size(), n_in);
        check("flush_no_out_xfer", outq.size(), n_out);
        check("post_flush_occ", int'(occupancy), 0);
        check("post_flush_out_valid", int'(out_valid), 0);
        check("post_flush_out_data", int'(out_data), 4'hC);
        repeat (5) tick();
        check("flush_nothing_emerges", outq.size(), 0);

        // 6: reset and flush together mid-stream; reset wins.
        clear_logs();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = W'(i + 8);
            tick();
        end
        reset = 1'b1; flush = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0; flush = 1'b0;
        #3;
        check("rst_flush_out_data", int'(out_data), 0);
        check("rst_flush_occ", int'(occupancy), 0);
        tick();
        clear_logs();
        push(4'h9);
        repeat (4) tick();
        check("restart_count", outq.size(), 1);
        if (outq.size() == 1 && in_cyc.size() == 1) begin
            check("restart_data", outq[0], 9);
            check("restart_latency", out_cyc[0] - in_cyc[0], 3);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
